// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Load/store memory controller between execute stage and data
//            memory. Decodes RV32 load/store instructions, aligns store data
//            onto byte lanes with byte enables, runs a req/gnt/rvalid
//            handshake and stalls the core while an access is in flight.
//            Loaded words are returned right-shifted so the addressed
//            byte/half sits at bit 0 for the downstream extension unit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   valid_i             inst_i/addr_i/wdata_i valid this cycle
//   inst_i              instruction (opcode [6:0], funct3 [14:12])
//   addr_i              effective byte address
//   wdata_i             store data (rs2)
//   stall_o             hold PC/pipeline
//   done_o              one-cycle pulse: instruction may retire
//   rdata_o             lane-shifted load word
//   misalign_o          one-cycle pulse: misaligned access rejected
//   err_o               one-cycle pulse: access aborted on timeout
//   mem_req_o           memory request
//   mem_we_o            1 = write
//   mem_addr_o          word-aligned address
//   mem_be_o            byte enables
//   mem_wdata_o         lane-replicated store data
//   mem_gnt_i           request accepted
//   mem_rvalid_i        read data valid
//   mem_rdata_i         read data
// ============================================================================
module lsu_mem_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] inst_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             misalign_o,
  output logic             err_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  localparam int               CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [6:0]       OPC_LOAD    = 7'b0000011;
  localparam logic [6:0]       OPC_STORE   = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             load_q;     // current access is a load
  logic [1:0]       offset_q;   // byte offset used to shift the load word

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load;
  logic       is_store;
  logic       is_mem_op;
  logic       misaligned;
  logic       in_idle;
  logic       accept;
  logic       reject;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  // Only rd/rs fields and the upper immediate bits are left unused here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_i[WIDTH-1:15], inst_i[11:7]};

  always_comb begin
    is_load = 1'b0;
    if (opcode == OPC_LOAD) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
        default:                                is_load = 1'b0;
      endcase
    end
  end

  assign is_store  = (opcode == OPC_STORE) && !funct3[2] && (funct3[1:0] != 2'b11);
  assign is_mem_op = is_load || is_store;

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // rst_n is folded in so the combinational IDLE responses are also quiet
  // while reset is held, even if the core keeps valid_i high.
  assign in_idle = rst_n && (state == IDLE);
  assign accept  = in_idle && valid_i && is_mem_op && !misaligned;
  assign reject  = in_idle && valid_i && is_mem_op && misaligned;

  // --------------------------------------------------------------------------
  // Byte-lane steering for the access being accepted
  // --------------------------------------------------------------------------
  logic [3:0]       be_next;
  logic [WIDTH-1:0] wdata_next;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata_i;
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr_i[1:0];
        wdata_next = WIDTH'({4{wdata_i[7:0]}});
      end
      2'b01: begin
        be_next    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_next = WIDTH'({2{wdata_i[15:0]}});
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata_i;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Timeout: the counter starts at zero on the first REQ cycle and counts
  // every REQ/WAIT cycle. The cycle in which it equals TIMEOUT is the abort
  // cycle: the request is withdrawn and any gnt/rvalid there is ignored.
  // --------------------------------------------------------------------------
  logic busy;
  logic timed_out;

  assign busy      = (state == REQ) || (state == WAIT);
  assign timed_out = busy && (count == TIMEOUT_CNT);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      load_q      <= 1'b0;
      offset_q    <= 2'b00;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= 4'b0000;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= REQ;
            count       <= '0;
            load_q      <= is_load;
            offset_q    <= addr_i[1:0];
            mem_we_o    <= is_store;
            mem_addr_o  <= {addr_i[WIDTH-1:2], 2'b00};
            mem_be_o    <= be_next;
            mem_wdata_o <= wdata_next;
          end
        end

        REQ: begin
          if (timed_out) begin
            rdata_o <= '0;
            state   <= RESP;
          end else begin
            count <= count + CNT_W'(1);
            if (mem_gnt_i) begin
              state <= load_q ? WAIT : RESP;
            end
          end
        end

        WAIT: begin
          if (timed_out) begin
            rdata_o <= '0;
            state   <= RESP;
          end else begin
            count <= count + CNT_W'(1);
            if (mem_rvalid_i) begin
              rdata_o <= mem_rdata_i >> {offset_q, 3'b000};
              state   <= RESP;
            end
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from the registered state; only the IDLE responses
  // (accept stall, misalign reject) depend on the current inputs.
  // --------------------------------------------------------------------------
  assign mem_req_o  = (state == REQ) && !timed_out;
  assign stall_o    = busy || accept;
  assign done_o     = (state == RESP) || reject;
  assign misalign_o = reject;
  assign err_o      = timed_out;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Purpose  : Self-checking bench for lsu_mem_ctrl. A transaction-level model
//            derives every expected output from the access rules (size,
//            alignment, lane arithmetic, handshake latencies, timeout budget)
//            and compares it cycle by cycle against the controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

  localparam int WIDTH = 32;
  localparam int TO    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_i;
  logic [WIDTH-1:0] inst_i;
  logic [WIDTH-1:0] addr_i;
  logic [WIDTH-1:0] wdata_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] rdata_o;
  logic             misalign_o;
  logic             err_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [WIDTH-1:0] mem_addr_o;
  logic [3:0]       mem_be_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic             mem_gnt_i;
  logic             mem_rvalid_i;
  logic [WIDTH-1:0] mem_rdata_i;

  lsu_mem_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .inst_i       (inst_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rdata;   // what rdata_o must currently hold

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r        = $urandom;
    r[6:0]   = opc;
    r[14:12] = f3;
    return r;
  endfunction

  // Outputs expected whenever nothing is in flight and nothing is accepted.
  task automatic check_quiet(input string tag);
    check({tag, ".stall"}, 32'(stall_o),    32'd0);
    check({tag, ".done"},  32'(done_o),     32'd0);
    check({tag, ".mis"},   32'(misalign_o), 32'd0);
    check({tag, ".err"},   32'(err_o),      32'd0);
    check({tag, ".req"},   32'(mem_req_o),  32'd0);
    check({tag, ".rdata"}, rdata_o,         model_rdata);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_i      = 1'b0;
    inst_i       = $urandom;
    mem_gnt_i    = 1'($urandom % 2);
    mem_rvalid_i = 1'($urandom % 2);
    mem_rdata_i  = $urandom;
    #1;
    check_quiet("idle");
  endtask

  // One instruction from presentation to retirement. gnt_lat / rv_lat are
  // the number of cycles the memory waits before gnt (counted from the
  // first REQ cycle) and before rvalid (counted from the first WAIT cycle).
  task automatic run_op(input logic [31:0] inst, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gnt_lat,
                        input int rv_lat, input logic [31:0] rd);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        ld, st, mis, fin, in_wait, tmo;
    int          nb, k, m;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;

    opc = inst[6:0];
    f3  = inst[14:12];
    ld  = (opc == 7'h03) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    st  = (opc == 7'h23) && (f3 <= 3'd2);
    nb  = 1 << (f3 % 4);
    mis = (addr % nb) != 0;
    exp_be = 4'(((1 << nb) - 1) << (addr % 4));
    if (nb == 1)      exp_wd = (wdata & 32'hFF)   * 32'h01010101;
    else if (nb == 2) exp_wd = (wdata & 32'hFFFF) * 32'h00010001;
    else              exp_wd = wdata;

    @(negedge clk);
    valid_i      = 1'b1;
    inst_i       = inst;
    addr_i       = addr;
    wdata_i      = wdata;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    #1;
    if (!(ld || st)) begin
      check_quiet("ignored");
      return;
    end
    if (mis) begin
      check("mis.flag",  32'(misalign_o), 32'd1);
      check("mis.done",  32'(done_o),     32'd1);
      check("mis.stall", 32'(stall_o),    32'd0);
      check("mis.req",   32'(mem_req_o),  32'd0);
      check("mis.err",   32'(err_o),      32'd0);
      check("mis.rdata", rdata_o,         model_rdata);
      return;
    end
    check("acc.stall", 32'(stall_o),    32'd1);
    check("acc.done",  32'(done_o),     32'd0);
    check("acc.req",   32'(mem_req_o),  32'd0);
    check("acc.mis",   32'(misalign_o), 32'd0);

    k = 0; m = 0; fin = 1'b0; in_wait = 1'b0;
    while (!fin) begin
      @(negedge clk);
      tmo = (k == TO);
      if (!in_wait) begin
        mem_gnt_i    = (k == gnt_lat);
        mem_rvalid_i = 1'($urandom % 2);
        mem_rdata_i  = $urandom;
      end else begin
        mem_gnt_i    = 1'($urandom % 2);
        mem_rvalid_i = (m == rv_lat);
        mem_rdata_i  = mem_rvalid_i ? rd : $urandom;
      end
      #1;
      check("busy.stall", 32'(stall_o),    32'd1);
      check("busy.done",  32'(done_o),     32'd0);
      check("busy.mis",   32'(misalign_o), 32'd0);
      check("busy.err",   32'(err_o),      32'(tmo));
      check("busy.req",   32'(mem_req_o),  32'(!in_wait && !tmo));
      if (!in_wait && !tmo) begin
        check("req.we",    32'(mem_we_o),  32'(st));
        check("req.addr",  mem_addr_o,     addr & 32'hFFFF_FFFC);
        check("req.be",    32'(mem_be_o),  32'(exp_be));
        if (st) check("req.wdata", mem_wdata_o, exp_wd);
      end
      if (tmo) begin
        model_rdata = 32'd0;
        fin = 1'b1;
      end else if (!in_wait && mem_gnt_i) begin
        if (st) fin = 1'b1;
        else begin
          in_wait = 1'b1;
          m = 0;
        end
      end else if (in_wait && mem_rvalid_i) begin
        model_rdata = rd >> (8 * (addr % 4));
        fin = 1'b1;
      end else if (in_wait) begin
        m++;
      end
      k++;
    end

    // Retire cycle; valid_i is still high and must not be taken again.
    @(negedge clk);
    mem_gnt_i    = 1'($urandom % 2);
    mem_rvalid_i = 1'($urandom % 2);
    mem_rdata_i  = $urandom;
    #1;
    check("resp.done",  32'(done_o),     32'd1);
    check("resp.stall", 32'(stall_o),    32'd0);
    check("resp.req",   32'(mem_req_o),  32'd0);
    check("resp.err",   32'(err_o),      32'd0);
    check("resp.mis",   32'(misalign_o), 32'd0);
    check("resp.rdata", rdata_o,         model_rdata);
  endtask

  // Start a word load and pull reset while in REQ (in_wait=0) or WAIT.
  task automatic reset_mid(input logic in_wait);
    @(negedge clk);
    valid_i      = 1'b1;
    inst_i       = mk_inst(7'h03, 3'b010);
    addr_i       = 32'h0000_0040;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    mem_gnt_i = in_wait;
    #1;
    check("rst.pre_req", 32'(mem_req_o), 32'd1);
    @(negedge clk);
    mem_gnt_i = 1'b0;
    #1;
    check("rst.pre_stall", 32'(stall_o), 32'd1);
    #1;
    rst_n = 1'b0;
    model_rdata = 32'd0;
    #1;
    check("rst.req",   32'(mem_req_o), 32'd0);
    check("rst.stall", 32'(stall_o),   32'd0);
    check("rst.rdata", rdata_o,        32'd0);
    check("rst.be",    32'(mem_be_o),  32'd0);
    check("rst.addr",  mem_addr_o,     32'd0);
    @(negedge clk);
    valid_i = 1'b0;
    rst_n   = 1'b1;
    idle_cycle();
    run_op(mk_inst(7'h23, 3'b010), 32'h0000_0100, 32'hCAFE_F00D, 0, 0, 32'd0);
    idle_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b1;
    valid_i      = 1'b0;
    inst_i       = '0;
    addr_i       = '0;
    wdata_i      = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    model_rdata  = 32'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset.we",    32'(mem_we_o),  32'd0);
    check("reset.addr",  mem_addr_o,     32'd0);
    check("reset.be",    32'(mem_be_o),  32'd0);
    check("reset.wdata", mem_wdata_o,    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // Directed scenarios
    run_op(mk_inst(7'h23, 3'b010), 32'h0000_0100, 32'hDEAD_BEEF, 1, 0, 32'd0);   // sw
    idle_cycle();
    run_op(mk_inst(7'h23, 3'b000), 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'd0);   // sb
    idle_cycle();
    run_op(mk_inst(7'h23, 3'b001), 32'h0000_0202, 32'h0000_1234, 2, 0, 32'd0);   // sh
    idle_cycle();
    run_op(mk_inst(7'h03, 3'b100), 32'h0000_0302, 32'd0, 0, 0, 32'h1122_3344);   // lbu
    idle_cycle();
    check("lbu.value", rdata_o, 32'h0000_1122);
    run_op(mk_inst(7'h03, 3'b010), 32'h0000_0101, 32'd0, 0, 0, 32'd0);           // lw misaligned
    idle_cycle();
    run_op(mk_inst(7'h03, 3'b001), 32'h0000_0103, 32'd0, 0, 0, 32'd0);           // lh misaligned
    idle_cycle();
    run_op(mk_inst(7'h03, 3'b010), 32'h0000_0400, 32'd0, 99, 0, 32'hFFFF_FFFF);  // timeout in REQ
    idle_cycle();
    run_op(mk_inst(7'h03, 3'b101), 32'h0000_0402, 32'd0, 0, 99, 32'h8765_4321);  // timeout in WAIT
    idle_cycle();
    run_op(mk_inst(7'h33, 3'b000), 32'h0000_0500, 32'd0, 0, 0, 32'd0);           // add: ignored
    idle_cycle();
    reset_mid(1'b1);
    reset_mid(1'b0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      logic [6:0]  opc;
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 7);
      if (sel < 3)       opc = 7'h03;
      else if (sel < 6)  opc = 7'h23;
      else if (sel == 6) opc = 7'h33;
      else               opc = 7'($urandom);
      a = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
      run_op(mk_inst(opc, 3'($urandom)), a, $urandom,
             $urandom_range(0, 5), $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store memory controller sitting between the core's execute stage and data memory; directly upstream of the load-data sign/zero-extension unit.
- Decodes load/store instructions, aligns store data to byte lanes with byte enables, runs a req/gnt/rvalid handshake to memory and stalls the core while busy.
- Returns the raw loaded word, right-shifted so the addressed byte/half sits in bits [7:0]/[15:0], for the extension unit to consume.

Parameters:
- WIDTH, 32, data/address width; byte-lane logic fixed at 4 lanes.
- TIMEOUT, 255, max cycles waiting in REQ+WAIT before abort; counter width = $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  inst_i/addr_i/wdata_i valid this cycle.
- inst_i  in  WIDTH  instruction; opcode [6:0], funct3 [14:12].
- addr_i  in  WIDTH  effective byte address from ALU.
- wdata_i  in  WIDTH  store data (rs2).
- stall_o  out  1  hold PC/pipeline.
- done_o  out  1  one-cycle pulse: access complete, instruction may retire.
- rdata_o  out  WIDTH  lane-shifted load word.
- misalign_o  out  1  one-cycle pulse: misaligned access rejected.
- err_o  out  1  one-cycle pulse: timeout abort.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  WIDTH  word address, {addr[WIDTH-1:2],2'b00}.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  WIDTH  lane-replicated store data.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  WIDTH  read data.

Behaviour:
- Reset: state IDLE, all outputs 0, counter 0, latched fields 0. Reset mid-access abandons it; mem_req_o drops asynchronously.
- Decode: load opcode 0000011 (funct3 000,001,010,100,101); store 0100011 (000,001,010). Any other opcode/funct3: ignored, no stall, no pulses.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00. Byte always aligned.
- States IDLE, REQ, WAIT, RESP.
- IDLE: valid_i & mem op & misaligned -> misalign_o=1 and done_o=1 same cycle, stall_o=0, no memory access, stay IDLE. valid_i & aligned mem op -> latch inst/addr/wdata, stall_o=1 combinationally this cycle, -> REQ.
- REQ: mem_req_o=1; we/addr/be/wdata stable until gnt. mem_gnt_i: store -> RESP; load -> WAIT. mem_rvalid_i ignored in REQ (memory gives rvalid >=1 cycle after gnt).
- WAIT: mem_req_o=0. On mem_rvalid_i: rdata_o <= mem_rdata_i >> (8*addr[1:0]); -> RESP.
- RESP: done_o=1, stall_o=0 for one cycle; -> IDLE. valid_i in RESP not re-accepted (same retiring instruction).
- stall_o = 1 in REQ and WAIT, and in IDLE on accept; 0 otherwise.
- Store lanes: sb be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; sh be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}; sw be=4'b1111, wdata as-is. Loads: mem_we_o=0, be per same rule.
- Timeout: counter clears on IDLE->REQ, increments each cycle in REQ/WAIT; reaching TIMEOUT -> err_o=1, rdata_o<=0, mem_req_o=0, -> RESP.
- gnt/rvalid when not expected are ignored. rdata_o holds until next load capture or timeout.

Test Plan:
- sw addr 0x100, wdata 0xDEADBEEF, gnt after 2 cycles -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF, stall 3 cycles, done pulse, then IDLE.
- sb addr 0x203, wdata 0x000000A5 -> mem_addr 0x200, be 1000, mem_wdata 0xA5A5A5A5; sh addr 0x202, wdata 0x1234 -> be 1100, mem_wdata 0x12341234.
- lbu addr 0x302, mem_rdata 0x11223344, gnt then rvalid 1 cycle later -> rdata_o 0x00001122, done pulse in cycle after rvalid.
- lw addr 0x101 -> misalign_o=1, done_o=1, stall_o=0, mem_req_o never asserted; lh addr 0x103 same.
- TIMEOUT=4, load with gnt never asserted -> err_o after 4 cycles in REQ, rdata_o 0, done_o next cycle; add instruction (0110011) -> no stall, no mem_req.
- rst_n low while in WAIT -> mem_req_o/stall_o 0 immediately; after release, new sw completes normally.
